rom_port_arbiter: RTL and testbench
===================================

Name: rom_port_arbiter

Overview:
- Shares the single combinational instruction ROM (10-bit word address, 32-bit data) between two requesters: the IF-stage fetch port and a debug/loader read port.
- Grants one requester per cycle, drives the ROM address and registers the returned word.
- Returns each word with fixed 1-cycle latency.
- Uses fixed IF priority with a starvation guard for the debug port; a pipeline flush cancels IF traffic.

Parameters:
- ADDR_W, 10, ROM word-address width.
- DATA_W, 32, ROM data width.
- STARVE_MAX, 4, consecutive denied debug-request cycles before the debug port is force-granted (legal range 1..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- if_req  input  1  IF fetch request.
- if_addr  input  ADDR_W  IF word address.
- if_gnt  output  1  IF request accepted this cycle (combinational).
- if_rvalid  output  1  IF read data valid.
- if_rdata  output  DATA_W  IF read data.
- flush  input  1  pipeline redirect; cancels IF grant/response.
- dbg_req  input  1  debug read request.
- dbg_addr  input  ADDR_W  debug word address.
- dbg_gnt  output  1  debug request accepted this cycle (combinational).
- dbg_rvalid  output  1  debug read data valid.
- dbg_rdata  output  DATA_W  debug read data.
- rom_addr  output  ADDR_W  address to ROM.
- rom_data_out  input  DATA_W  ROM combinational data.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset: on any rising edge with rst=1, all registers clear:
  - starvation counter = 0, last_addr = 0.
  - if_rvalid_q = dbg_rvalid_q = 0; if_rdata = dbg_rdata = 0.
  - While rst=1, if_gnt = dbg_gnt = 0 and rom_addr = 0.
  - Reset mid-transaction drops any pending response; no rvalid appears in the cycle after reset.
- Grant (combinational, at most one per cycle):
  - force_dbg = dbg_req & (starve_cnt == STARVE_MAX).
  - dbg_gnt = dbg_req & (force_dbg | ~(if_req & ~flush)).
  - if_gnt = if_req & ~flush & ~dbg_gnt.
  - if_gnt and dbg_gnt are never both 1.
- ROM address:
  - rom_addr = if_addr when if_gnt; dbg_addr when dbg_gnt.
  - Otherwise it holds last_addr, so the ROM input does not toggle when idle.
  - last_addr updates to the granted address on every grant edge.
- Response, latency 1:
  - On an edge where a port was granted, that port's rdata register <= rom_data_out and its rvalid_q <= 1.
  - Otherwise rvalid_q <= 0 and rdata holds its last value.
  - dbg_rvalid = dbg_rvalid_q.
  - if_rvalid = if_rvalid_q & ~flush: a flush in the response cycle suppresses the IF response; if_rdata still updates.
  - Back-to-back grants give back-to-back rvalids (full throughput, 1 word/cycle total).
- Starvation counter (4-bit):
  - If dbg_req & ~dbg_gnt: increment, saturating at STARVE_MAX.
  - If dbg_gnt: clear to 0.
  - If ~dbg_req: clear to 0.
  - After a forced debug grant the counter restarts, so IF regains priority the next cycle.
- Flush:
  - Blocks if_gnt in the same cycle.
  - Debug may be granted in a flush cycle.
  - Flush does not clear the starvation counter.
- No internal buffering: a requester not granted must hold req and addr stable until granted; the block never queues.

Test Plan:
- Reset: assert rst for 2 cycles with if_req=1, if_addr=0x005 -> if_gnt=0, rom_addr=0, all rvalid=0, rdata=0. Release -> if_gnt=1 in the first cycle, if_rvalid=1 with ROM[0x005] one cycle later.
- IF streaming: if_req=1 with if_addr 0x000,0x001,0x002 on consecutive cycles, ROM model word=addr*4 -> if_rvalid high 3 consecutive cycles, if_rdata 0x0,0x4,0x8.
- Contention/starvation, STARVE_MAX=4: if_req and dbg_req held high with dbg_addr=0x3FF -> IF granted cycles 0-3, dbg_gnt in cycle 4, dbg_rdata=ROM[0x3FF] at cycle 5, IF granted again in cycle 5; pattern repeats every 5 cycles.
- Flush: IF granted addr 0x010 in cycle N, flush=1 in N+1 -> if_rvalid=0 in N+1 and if_gnt=0 in N+1. With dbg_req=1 in N+1 -> dbg_gnt=1 in N+1, dbg_rvalid=1 in N+2.
- Idle hold: grant dbg_addr=0x123, then no requests for 3 cycles -> rom_addr stays 0x123, rvalids 0, dbg_rdata holds its value.
- Reset mid-operation: IF granted in cycle N, rst=1 in N+1 -> if_rvalid_q cleared, no if_rvalid in N+1 or N+2, counter=0.

Source files
------------

// File: rtl/rom_port_arbiter.sv
// rtl/rom_port_arbiter.sv - two-port arbiter in front of a combinational instruction ROM
module rom_port_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              flush,
    input  logic              dbg_req,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data_out
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0]        starve_cnt;
    logic [ADDR_W-1:0] last_addr;
    logic              if_rvalid_q;
    logic              dbg_rvalid_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] dbg_rdata_q;
    logic              force_dbg;
    logic              if_live;

    always_comb begin
        force_dbg = dbg_req & (starve_cnt == STARVE_LIM);
        if_live   = if_req & ~flush;
        dbg_gnt   = ~rst & dbg_req & (force_dbg | ~if_live);
        if_gnt    = ~rst & if_live & ~dbg_gnt;
        // Idle cycles replay the last address so the ROM input stays quiet.
        if (rst) begin
            rom_addr = '0;
        end else if (if_gnt) begin
            rom_addr = if_addr;
        end else if (dbg_gnt) begin
            rom_addr = dbg_addr;
        end else begin
            rom_addr = last_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt   <= '0;
            last_addr    <= '0;
            if_rvalid_q  <= 1'b0;
            dbg_rvalid_q <= 1'b0;
            if_rdata_q   <= '0;
            dbg_rdata_q  <= '0;
        end else begin
            if_rvalid_q  <= if_gnt;
            dbg_rvalid_q <= dbg_gnt;
            if (if_gnt) begin
                if_rdata_q <= rom_data_out;
            end
            if (dbg_gnt) begin
                dbg_rdata_q <= rom_data_out;
            end
            if (if_gnt | dbg_gnt) begin
                last_addr <= rom_addr;
            end
            // Saturate while denied; any grant or dropped request restarts the count.
            if (dbg_req & ~dbg_gnt) begin
                if (starve_cnt != STARVE_LIM) begin
                    starve_cnt <= starve_cnt + 4'd1;
                end
            end else begin
                starve_cnt <= '0;
            end
        end
    end

    // A response still in flight when reset arrives is never presented.
    assign if_rvalid  = if_rvalid_q & ~flush & ~rst;
    assign dbg_rvalid = dbg_rvalid_q & ~rst;
    assign if_rdata   = if_rdata_q;
    assign dbg_rdata  = dbg_rdata_q;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// tb/tb_rom_port_arbiter.sv - directed vector bench for rom_port_arbiter
module tb_rom_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [9:0]  if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        flush;
    logic        dbg_req;
    logic [9:0]  dbg_addr;
    logic        dbg_gnt;
    logic        dbg_rvalid;
    logic [31:0] dbg_rdata;
    logic [9:0]  rom_addr;
    logic [31:0] rom_data_out;

    always #5 clk = ~clk;

    // ROM model: word = address * 4
    assign rom_data_out = {20'h0, rom_addr, 2'b00};

    rom_port_arbiter #(.ADDR_W(10), .DATA_W(32), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .flush(flush),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_gnt(dbg_gnt),
        .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .rom_addr(rom_addr), .rom_data_out(rom_data_out)
    );

    typedef struct {
        logic        rst;
        logic        if_req;
        logic [9:0]  if_addr;
        logic        flush;
        logic        dbg_req;
        logic [9:0]  dbg_addr;
        logic        e_if_gnt;
        logic        e_dbg_gnt;
        logic [9:0]  e_rom_addr;
        logic        e_if_rvalid;
        logic [31:0] e_if_rdata;
        logic        e_dbg_rvalid;
        logic [31:0] e_dbg_rdata;
        logic        chk_rdata;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;
    int   step  = 0;

    function automatic vec_t mk(logic r, logic ir, logic [9:0] ia, logic fl, logic dr, logic [9:0] da,
                                logic eig, logic edg, logic [9:0] era, logic eiv, logic [31:0] eid,
                                logic edv, logic [31:0] edd, logic chk);
        vec_t v;
        v.rst = r; v.if_req = ir; v.if_addr = ia; v.flush = fl; v.dbg_req = dr; v.dbg_addr = da;
        v.e_if_gnt = eig; v.e_dbg_gnt = edg; v.e_rom_addr = era; v.e_if_rvalid = eiv;
        v.e_if_rdata = eid; v.e_dbg_rvalid = edv; v.e_dbg_rdata = edd; v.chk_rdata = chk;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step=%0d got=%h want=%h", name, step, act, exp);
        end
    endtask

    task automatic apply(logic r, logic ir, logic [9:0] ia, logic fl, logic dr, logic [9:0] da);
        @(negedge clk);
        rst = r; if_req = ir; if_addr = ia; flush = fl; dbg_req = dr; dbg_addr = da;
        #1;
    endtask

    initial begin
        rst = 1'b1; if_req = 1'b0; if_addr = '0; flush = 1'b0; dbg_req = 1'b0; dbg_addr = '0;

        // reset with IF already requesting
        vecs.push_back(mk(1,1,10'h005,0,0,0,     0,0,10'h000,0,32'h0,0,32'h0,0));
        vecs.push_back(mk(1,1,10'h005,0,0,0,     0,0,10'h000,0,32'h0,0,32'h0,1));
        vecs.push_back(mk(0,1,10'h005,0,0,0,     1,0,10'h005,0,32'h0,0,32'h0,1));
        // IF streaming
        vecs.push_back(mk(0,1,10'h000,0,0,0,     1,0,10'h000,1,32'h14,0,32'h0,1));
        vecs.push_back(mk(0,1,10'h001,0,0,0,     1,0,10'h001,1,32'h0,0,32'h0,1));
        vecs.push_back(mk(0,1,10'h002,0,0,0,     1,0,10'h002,1,32'h4,0,32'h0,1));
        vecs.push_back(mk(0,0,10'h000,0,0,0,     0,0,10'h002,1,32'h8,0,32'h0,1));
        vecs.push_back(mk(0,0,10'h000,0,0,0,     0,0,10'h002,0,32'h8,0,32'h0,1));
        // contention: forced debug grant every fifth cycle
        vecs.push_back(mk(0,1,10'h020,0,1,10'h3FF, 1,0,10'h020,0,32'h8,0,32'h0,1));
        vecs.push_back(mk(0,1,10'h020,0,1,10'h3FF, 1,0,10'h020,1,32'h80,0,32'h0,1));
        vecs.push_back(mk(0,1,10'h020,0,1,10'h3FF, 1,0,10'h020,1,32'h80,0,32'h0,1));
        vecs.push_back(mk(0,1,10'h020,0,1,10'h3FF, 1,0,10'h020,1,32'h80,0,32'h0,1));
        vecs.push_back(mk(0,1,10'h020,0,1,10'h3FF, 0,1,10'h3FF,1,32'h80,0,32'h0,1));
        vecs.push_back(mk(0,1,10'h020,0,1,10'h3FF, 1,0,10'h020,0,32'h80,1,32'hFFC,1));
        vecs.push_back(mk(0,1,10'h020,0,1,10'h3FF, 1,0,10'h020,1,32'h80,0,32'hFFC,1));
        vecs.push_back(mk(0,1,10'h020,0,1,10'h3FF, 1,0,10'h020,1,32'h80,0,32'hFFC,1));
        vecs.push_back(mk(0,1,10'h020,0,1,10'h3FF, 1,0,10'h020,1,32'h80,0,32'hFFC,1));
        vecs.push_back(mk(0,1,10'h020,0,1,10'h3FF, 0,1,10'h3FF,1,32'h80,0,32'hFFC,1));
        vecs.push_back(mk(0,1,10'h020,0,1,10'h3FF, 1,0,10'h020,0,32'h80,1,32'hFFC,1));
        // flush in the response cycle, debug granted alongside
        vecs.push_back(mk(0,1,10'h010,0,0,0,     1,0,10'h010,1,32'h80,0,32'hFFC,1));
        vecs.push_back(mk(0,1,10'h010,1,1,10'h040, 0,1,10'h040,0,32'h40,0,32'hFFC,1));
        vecs.push_back(mk(0,1,10'h010,0,0,0,     1,0,10'h010,0,32'h40,1,32'h100,1));
        // idle hold after a debug grant
        vecs.push_back(mk(0,0,10'h000,0,1,10'h123, 0,1,10'h123,1,32'h40,0,32'h100,1));
        vecs.push_back(mk(0,0,10'h000,0,0,0,     0,0,10'h123,0,32'h40,1,32'h48C,1));
        vecs.push_back(mk(0,0,10'h000,0,0,0,     0,0,10'h123,0,32'h40,0,32'h48C,1));
        vecs.push_back(mk(0,0,10'h000,0,0,0,     0,0,10'h123,0,32'h40,0,32'h48C,1));
        // reset mid-operation
        vecs.push_back(mk(0,1,10'h033,0,0,0,     1,0,10'h033,0,32'h40,0,32'h48C,1));
        vecs.push_back(mk(1,1,10'h033,0,1,10'h007, 0,0,10'h000,0,32'hCC,0,32'h48C,1));
        vecs.push_back(mk(0,0,10'h000,0,0,0,     0,0,10'h000,0,32'h0,0,32'h0,1));
        vecs.push_back(mk(0,0,10'h000,0,0,0,     0,0,10'h000,0,32'h0,0,32'h0,1));

        foreach (vecs[i]) begin
            step = i;
            apply(vecs[i].rst, vecs[i].if_req, vecs[i].if_addr,
                  vecs[i].flush, vecs[i].dbg_req, vecs[i].dbg_addr);
            chk("if_gnt", 32'(if_gnt), 32'(vecs[i].e_if_gnt));
            chk("dbg_gnt", 32'(dbg_gnt), 32'(vecs[i].e_dbg_gnt));
            chk("gnt_excl", 32'(if_gnt & dbg_gnt), 32'h0);
            chk("rom_addr", 32'(rom_addr), 32'(vecs[i].e_rom_addr));
            chk("if_rvalid", 32'(if_rvalid), 32'(vecs[i].e_if_rvalid));
            chk("dbg_rvalid", 32'(dbg_rvalid), 32'(vecs[i].e_dbg_rvalid));
            if (vecs[i].chk_rdata) begin
                chk("if_rdata", if_rdata, vecs[i].e_if_rdata);
                chk("dbg_rdata", dbg_rdata, vecs[i].e_dbg_rdata);
            end
        end

        // counter built to 3 must be wiped by reset: four IF grants again before the forced one
        step = 100;
        apply(1, 0, 10'h0, 0, 0, 10'h0);
        for (int k = 0; k < 3; k++) begin
            step = 101 + k;
            apply(0, 1, 10'h002, 0, 1, 10'h009);
            chk("pre_rst_if_gnt", 32'(if_gnt), 32'h1);
        end
        step = 104;
        apply(1, 1, 10'h002, 0, 1, 10'h009);
        chk("rst_dbg_gnt", 32'(dbg_gnt), 32'h0);
        for (int k = 0; k < 5; k++) begin
            step = 105 + k;
            apply(0, 1, 10'h002, 0, 1, 10'h009);
            chk("post_rst_if_gnt", 32'(if_gnt), (k < 4) ? 32'h1 : 32'h0);
            chk("post_rst_dbg_gnt", 32'(dbg_gnt), (k < 4) ? 32'h0 : 32'h1);
        end
        step = 110;
        apply(0, 0, 10'h0, 0, 0, 10'h0);
        chk("forced_dbg_rvalid", 32'(dbg_rvalid), 32'h1);
        chk("forced_dbg_rdata", dbg_rdata, 32'h24);
        chk("last_if_rdata", if_rdata, 32'h8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
